// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Opcode, FSM state and operand-width defaults used by muldiv_unit and its bench.
package muldiv_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign correction: turns unsigned magnitude results into signed HI/LO.
// Product is negated as a whole; quotient follows a^b, remainder follows the dividend.
module muldiv_signfix #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic            neg_a,
  input  logic            neg_b,
  input  logic [XLEN-1:0] mag_hi,
  input  logic [XLEN-1:0] mag_lo,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic            neg_res;
  logic [2*XLEN-1:0] prod_neg;

  always_comb begin
    neg_res  = neg_a ^ neg_b;
    prod_neg = -{mag_hi, mag_lo};
    hi       = mag_hi;
    lo       = mag_lo;
    if (is_div) begin
      if (neg_res) lo = -mag_lo;
      if (neg_a)   hi = -mag_hi;
    end else if (neg_res) begin
      hi = prod_neg[2*XLEN-1:XLEN];
      lo = prod_neg[XLEN-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply / restoring divide with HI/LO result registers.
// Define MULDIV_SIGNED_EN to make ops 00/10 signed; otherwise every op is unsigned.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  state_e            state;
  logic [CW-1:0]     count;
  logic              is_div;
  logic              b_zero;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   rem;
  logic [2*XLEN-1:0] acc;

  logic [XLEN-1:0]   cap_a;
  logic [XLEN-1:0]   cap_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [XLEN-1:0]   res_hi;
  logic [XLEN-1:0]   res_lo;
  logic [XLEN-1:0]   fix_hi;
  logic [XLEN-1:0]   fix_lo;
  logic [XLEN-1:0]   dz_hi;

`ifdef MULDIV_SIGNED_EN
  logic            neg_a;
  logic            neg_b;
  logic            cap_neg_a;
  logic            cap_neg_b;
  logic [XLEN-1:0] a_raw;

  always_comb begin
    cap_neg_a = op_is_signed(op) & a[XLEN-1];
    cap_neg_b = op_is_signed(op) & b[XLEN-1];
    cap_a     = cap_neg_a ? -a : a;
    cap_b     = cap_neg_b ? -b : b;
  end

  muldiv_signfix #(.XLEN(XLEN)) u_signfix (
    .is_div (is_div),
    .neg_a  (neg_a),
    .neg_b  (neg_b),
    .mag_hi (res_hi),
    .mag_lo (res_lo),
    .hi     (fix_hi),
    .lo     (fix_lo)
  );

  // Divide-by-zero returns the dividend as written, not its magnitude.
  assign dz_hi = a_raw;
`else
  assign cap_a  = a;
  assign cap_b  = b;
  assign fix_hi = res_hi;
  assign fix_lo = res_lo;
  assign dz_hi  = mag_a;
`endif

  // Multiply: acc = {partial, multiplier}; divide: acc[XLEN-1:0] shifts dividend out, quotient in.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_shift = {rem, acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    res_hi    = is_div ? rem : acc[2*XLEN-1:XLEN];
    res_lo    = acc[XLEN-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      b_zero <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      rem    <= '0;
      acc    <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      a_raw  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div <= op_is_div(op);
            b_zero <= (b == '0);
            mag_a  <= cap_a;
            mag_b  <= cap_b;
            acc    <= {{XLEN{1'b0}}, (op_is_div(op) ? cap_a : cap_b)};
            rem    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
`ifdef MULDIV_SIGNED_EN
            neg_a  <= cap_neg_a;
            neg_b  <= cap_neg_b;
            a_raw  <= a;
`endif
          end
        end
        S_RUN: begin
          count <= count + CW'(1);
          if (is_div) begin
            if (!div_diff[XLEN]) begin
              rem <= div_diff[XLEN-1:0];
              acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], 1'b1};
            end else begin
              rem <= div_shift[XLEN-1:0];
              acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], 1'b0};
            end
          end else begin
            acc <= {mul_sum, acc[XLEN-1:1]};
          end
          if (count == CW'(XLEN-1)) state <= S_FIN;
        end
        S_FIN: begin
          if (is_div && b_zero) begin
            hi <= dz_hi;
            lo <= '1;
          end else begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: fixed vectors with hand-computed HI/LO, latency,
// busy width, start-while-busy, start-in-done-cycle and asynchronous reset mid-op.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  int check_cnt  = 0;
  int pass_cnt   = 0;
  int cyc        = 0;
  int busy_total = 0;
  int t_start    = 0;
  int busy_mark  = 0;

  logic [2*XLEN-1:0] exp_q[$];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy) busy_total <= busy_total + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // driver: present a request for one edge, then scramble the operand inputs
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk); #1;
    t_start   = cyc;
    busy_mark = busy_total;
    start     = 1'b0;
    op        = 2'($urandom_range(3, 0));
    a         = $urandom;
    b         = $urandom;
    check("busy_on_start", {31'b0, busy}, 32'd1);
    check("done_on_start", {31'b0, done}, 32'd0);
  endtask

  // scoreboard: wait (bounded) for done, then compare latency, busy width and HI/LO
  task automatic wait_done(input string tag);
    logic [2*XLEN-1:0] e;
    int guard;
    guard = 0;
    while (!done && guard < 60) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_lat"}, 32'(cyc - t_start), 32'd33);
    check({tag, "_busy"}, 32'(busy_total - busy_mark), 32'd33);
    e = exp_q.pop_front();
    check({tag, "_hi"}, hi, e[63:32]);
    check({tag, "_lo"}, lo, e[31:0]);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    exp_q.push_back({eh, el});
    issue(o, x, y);
    wait_done(tag);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] mult_hi, div_hi, div_lo, ovf_hi, ovf_lo, big_hi;
`ifdef MULDIV_SIGNED_EN
    mult_hi = 32'hFFFF_FFFF;
    div_hi  = 32'hFFFF_FFFE;
    div_lo  = 32'hFFFF_FFF2;
    ovf_hi  = 32'h0000_0000;
    ovf_lo  = 32'h8000_0000;
    big_hi  = 32'hFFFF_FFFF;
`else
    mult_hi = 32'h0000_0005;
    div_hi  = 32'h0000_0002;
    div_lo  = 32'h2492_4916;
    ovf_hi  = 32'h8000_0000;
    ovf_lo  = 32'h0000_0000;
    big_hi  = 32'h0000_0001;
`endif
    rst   = 1'b1;
    start = 1'b0;
    op    = OP_MULTU;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    repeat (4) begin
      a = $urandom;
      b = $urandom;
      @(posedge clk); #1;
    end
    check("hold_hi", hi, 32'hFFFF_FFFE);
    check("hold_lo", lo, 32'h0000_0001);

    run("mult_neg7x6", OP_MULT, 32'hFFFF_FFF9, 32'd6, mult_hi, 32'hFFFF_FFD6);
    run("mult_small", OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15);
    run("mult_carry", OP_MULT, 32'h8000_0000, 32'd2, big_hi, 32'h0000_0000);
    run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, div_hi, div_lo);
    run("divu_by0", OP_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, ovf_hi, ovf_lo);
    run("div_by0_neg", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // start while busy must be ignored; operands changing mid-op must not matter
    exp_q.push_back({32'd2, 32'd14});
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    op    = OP_MULTU;
    a     = 32'd9;
    b     = 32'd3;
    repeat (3) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_done("busy_start");

    // request presented in the done cycle is taken on the next edge
    check("done_cycle", {31'b0, done}, 32'd1);
    exp_q.push_back({32'd1, 32'd0});
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_done("b2b");

    // asynchronous reset part-way through an operation
    issue(OP_MULTU, 32'h0000_DEAD, 32'h0000_BEEF);
    repeat (10) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("arst_idle", {31'b0, busy}, 32'd0);
    run("after_rst", OP_DIVU, 32'd1000, 32'd33, 32'd10, 32'd30);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide execute unit directly downstream of the register file.
- Consumes the two read-port operands (data1, data2) on a start strobe and computes a 64-bit product, or a quotient/remainder, over 32 iteration cycles.
- Results are held in HI/LO registers for the writeback path to read.
- Serves MULT/MULTU/DIV/DIVU-class instructions that the single-cycle ALU cannot complete in one cycle.

Parameters:
- XLEN, 32, operand width; HI/LO are XLEN bits each; the iteration count equals XLEN.

Ports:
- clk    input   1     rising-edge clock
- rst    input   1     asynchronous, active-high reset
- start  input   1     request; sampled only in IDLE
- op     input   2     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a      input   XLEN  operand 1 (from regfile data1); multiplicand / dividend
- b      input   XLEN  operand 2 (from regfile data2); multiplier / divisor
- busy   output  1     high while an operation is in flight
- done   output  1     one-cycle pulse when HI/LO are updated
- hi     output  XLEN  product[63:32] or remainder
- lo     output  XLEN  product[31:0] or quotient

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, busy=0, done=0, hi=0, lo=0, count=0.
  - Any in-flight operation is discarded.
- States: IDLE -> RUN -> FIN -> IDLE.
- IDLE:
  - On an edge with start=1: latch op, a and b. For signed ops, latch magnitudes plus the sign flags neg_a and neg_b.
  - count=0, state=RUN, busy=1.
  - start=0: remain in IDLE.
- RUN: one iteration per edge; count increments; after the edge where count==XLEN-1, state=FIN.
  - Multiply: shift-add on a 2*XLEN accumulator.
  - Divide: restoring shift-subtract; remainder width XLEN+1 for the subtract.
- FIN (one cycle):
  - Apply sign fix-up.
  - Update hi/lo, done=1, busy=0, state=IDLE.
- Latency:
  - start captured at edge E0; iterations on E1..E32; hi/lo valid and done=1 after E33.
  - done is low after E34 unless a new op finishes then.
- busy is registered: high from after E0 through E32, low after E33.
- start while busy=1: ignored; no queueing.
- start in the cycle done=1: accepted; the state is IDLE in that cycle.
- Operands are captured once at start; later changes on a/b have no effect.
- hi/lo hold their value between operations. They change only in FIN or on reset.
- Signed multiply: product = mag_a*mag_b; negate the 64-bit result if neg_a^neg_b.
- Signed divide:
  - Quotient negated if neg_a^neg_b.
  - Remainder takes the sign of a.
- Divide by zero (b==0, signed or unsigned): lo=all ones, hi=a unchanged. Same 33-cycle latency.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0.
- Unsigned ops ignore operand signs entirely.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined: op 00/10 are signed, as specified above.
- Undefined:
  - op[0] is ignored and all ops are unsigned.
  - No magnitude/sign fix-up logic is built.
  - FIN still takes one cycle, so latency is unchanged.

Decomposition:
- Shared package holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state encodings: S_IDLE, S_RUN, S_FIN
  - XLEN default
- One natural sub-module: muldiv_signfix. It is combinational; it takes the magnitudes plus neg_a/neg_b and produces the signed HI/LO. It is omitted when MULDIV_SIGNED_EN is undefined.
- The FSM, counter and datapath stay in muldiv_unit.

Test Plan:
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT (signed build), a=-7 (0xFFFFFFF9), b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6.
- DIVU a=100, b=7 -> lo=14, hi=2. Then DIV a=-100, b=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2).
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678. Then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Issue start at cycle 5 while busy, changing a/b mid-op -> no effect on the result. Issue start during the done cycle -> second op accepted, its done arrives exactly 33 cycles later.
- Assert rst at iteration 10 -> busy, done, hi and lo are all 0 immediately (asynchronously). Start after reset release -> normal 33-cycle completion with the correct result.
